// File: rtl/unified_mem_arbiter.sv
// Arbitrates the IF fetch port and the MEM data port onto one fixed-latency
// single-port memory, with store lane formatting and load extension.
module unified_mem_arbiter #(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D, WAIT_X} state_t;
  state_t state, state_n;

  logic [2:0]  cnt;
  logic [3:0]  streak;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;

  logic        i_elig, d_elig, d_mis, starve, d_win, i_win, d_go, mis_hit;
  logic        at_lat, fire_i, fire_d;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_data;
  logic [7:0]  lb;
  logic [15:0] lh;

  // A port whose completion pulse is up is still holding req for that cycle.
  assign i_elig  = if_req & ~if_flush & ~if_valid;
  assign d_elig  = d_req & ~d_valid;
  assign d_mis   = ((d_funct3[1:0] == 2'b01) & d_addr[0]) |
                   (d_funct3[1] & (d_addr[1:0] != 2'b00));
  assign starve  = (streak == 4'(STARVE_MAX)) & i_elig;
  assign d_win   = (state == IDLE) & d_elig & ~starve;
  assign i_win   = (state == IDLE) & i_elig & ~d_win;
  assign d_go    = d_win & ~d_mis;
  assign mis_hit = d_win & d_mis;

  assign at_lat  = (cnt == 3'(LAT));
  assign fire_i  = (state == WAIT_I) & at_lat & ~if_flush;
  assign fire_d  = (state == WAIT_D) & (we_q ? (cnt == 3'd0) : at_lat);

  always_comb begin
    st_be   = 4'b1111;
    st_data = d_wdata;
    case (d_funct3[1:0])
      2'b00: begin st_be = 4'b0001 << d_addr[1:0];        st_data = {4{d_wdata[7:0]}};  end
      2'b01: begin st_be = 4'b0011 << {d_addr[1], 1'b0}; st_data = {2{d_wdata[15:0]}}; end
      default: ;
    endcase
  end

  always_comb begin
    lb = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lh = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_data = {{24{lb[7]}}, lb};
      3'b100:  ld_data = {24'd0, lb};
      3'b001:  ld_data = {{16{lh[15]}}, lh};
      3'b101:  ld_data = {16'd0, lh};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (d_go) state_n = WAIT_D; else if (i_win) state_n = WAIT_I;
      WAIT_I:  if (at_lat) state_n = IDLE; else if (if_flush) state_n = WAIT_X;
      WAIT_X:  if (at_lat) state_n = IDLE;
      WAIT_D:  if (fire_d) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      streak   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      f3_q     <= '0;
      if_rdata <= '0;
      if_valid <= 1'b0;
      d_rdata  <= '0;
      d_valid  <= 1'b0;
      d_err    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state == IDLE) ? 3'd0 : cnt + 3'd1;
      if (d_go) begin
        addr_q  <= d_addr;
        we_q    <= d_we;
        be_q    <= d_we ? st_be : 4'b1111;
        wdata_q <= d_we ? st_data : 32'd0;
        f3_q    <= d_funct3;
      end else if (i_win) begin
        addr_q  <= if_addr;
        we_q    <= 1'b0;
        be_q    <= 4'b1111;
        wdata_q <= 32'd0;
        f3_q    <= 3'b010;
      end
      // Misaligned rejects count as data grants so they cannot starve fetch.
      if (i_win)
        streak <= '0;
      else if (d_win & i_elig)
        streak <= (streak == 4'(STARVE_MAX)) ? streak : streak + 4'd1;
      else if (!if_req)
        streak <= '0;
      if_valid <= fire_i;
      if (fire_i) if_rdata <= mem_rdata;
      d_valid <= fire_d | mis_hit;
      d_err   <= mis_hit;
      if (fire_d & ~we_q) d_rdata <= ld_data;
    end
  end

  assign busy      = (state != IDLE);
  assign mem_req   = busy & (cnt == 3'd0);
  assign mem_we    = busy & we_q;
  assign mem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be    = busy ? be_q : 4'd0;
  assign mem_wdata = busy ? wdata_q : 32'd0;
  assign if_stall  = if_req & ~if_valid;
  assign d_stall   = d_req & ~d_valid;

endmodule
